// File: rtl/control_display_suma.sv
// control_display_suma: captures A and B on a synchronized rising edge of cargar,
// adds them, and multiplexes sum/opB/opA onto a 4-digit active-low 7-segment display.
module control_display_suma #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] A,
  input  logic [2:0] B,
  input  logic       cargar,
  output logic [0:6] SSeg,
  output logic [3:0] an,
  output logic       listo
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
  logic [2:0] sync_q, sync_d;
  logic prim_q, prim_d, arm_q, arm_d, pend_q, pend_d, listo_q, listo_d, cap, wrap;
  logic [2:0] opa_q, opa_d, opb_q, opb_d;
  logic [3:0] suma_q, suma_d, units, code;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] dig_q, dig_d;

  function automatic logic [0:6] glyph(input logic [3:0] v);
    case (v)
      4'd0: glyph = 7'b0000001;
      4'd1: glyph = 7'b1001111;
      4'd2: glyph = 7'b0010010;
      4'd3: glyph = 7'b0000110;
      4'd4: glyph = 7'b1001100;
      4'd5: glyph = 7'b0100100;
      4'd6: glyph = 7'b0100000;
      4'd7: glyph = 7'b0001111;
      4'd8: glyph = 7'b0000000;
      4'd9: glyph = 7'b0000100;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // arm_q only sets after a genuinely sampled low, so a button held through reset cannot capture
  always_comb begin
    sync_d  = {sync_q[1:0], cargar};
    prim_d  = 1'b1;
    arm_d   = arm_q | (prim_q & ~sync_q[0]);
    cap     = arm_q & sync_q[1] & ~sync_q[2];
    pend_d  = cap;
    opa_d   = cap ? A : opa_q;
    opb_d   = cap ? B : opb_q;
    suma_d  = pend_q ? {1'b0, opa_q} + {1'b0, opb_q} : suma_q;
    listo_d = listo_q | pend_q;
    wrap    = div_q == DIV_MAX;
    div_d   = wrap ? '0 : div_q + 1'b1;
    dig_d   = wrap ? dig_q + 1'b1 : dig_q;
    units   = suma_q >= 4'd10 ? suma_q - 4'd10 : suma_q;
    code    = dig_q == 2'd0 ? units :
              dig_q == 2'd1 ? (suma_q >= 4'd10 ? 4'd1 : 4'd15) :
              dig_q == 2'd2 ? {1'b0, opb_q} : {1'b0, opa_q};
    SSeg    = listo_q ? glyph(code) : 7'b1111110;
    an      = ~(4'b0001 << dig_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      prim_q  <= 1'b0;
      arm_q   <= 1'b0;
      pend_q  <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      suma_q  <= '0;
      listo_q <= 1'b0;
      div_q   <= '0;
      dig_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prim_q  <= prim_d;
      arm_q   <= arm_d;
      pend_q  <= pend_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      suma_q  <= suma_d;
      listo_q <= listo_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
    end
  end

  assign listo = listo_q;
endmodule
